// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add / subtract / signed set-less-than unit.
//
// One operand bit pair is consumed per cycle, LSB first, through a single full
// adder with a registered carry. Results and flags are registered at the
// completion edge, so no combinational path runs from the inputs to the outputs.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled only when idle
//   op     in   [2]=0 add, [2]=1 subtract, 3'b111 signed set-less-than
//   a, b   in   operands, captured together with start
//   busy   out  high while an operation is running
//   done   out  one-cycle pulse when y and the flags update
//   y      out  result; holds until the next completion
//   cout   out  carry out of the MSB (for subtract: no borrow)
//   ovf    out  signed overflow
//   zero   out  y == 0
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StRun} stateT;

    stateT            stateQ, stateD;
    logic [WIDTH-1:0] aSrQ, aSrD, bSrQ, bSrD, resSrQ, resSrD;
    logic             carryQ, carryD, subQ, subD, sltQ, sltD;
    logic [CntW-1:0]  cntQ, cntD;
    logic [WIDTH-1:0] yQ, yD;
    logic             coutQ, coutD, ovfQ, ovfD, zeroQ, zeroD, doneQ, doneD;

    logic             bsel, sumBit, carryOut, cmsb, ovfBit;
    logic [WIDTH-1:0] sumFull, resultNext;

    // Datapath: one full adder slice on the current LSBs.
    assign bsel     = subQ ? ~bSrQ[0] : bSrQ[0];
    assign sumBit   = aSrQ[0] ^ bsel ^ carryQ;
    assign carryOut = (aSrQ[0] & bsel) | (aSrQ[0] & carryQ) | (bsel & carryQ);
    assign sumFull  = {sumBit, resSrQ[WIDTH-1:1]};
    // On the final bit the registered carry is the carry entering the MSB.
    assign cmsb     = carryQ;
    assign ovfBit   = cmsb ^ carryOut;
    // Signed less-than: true sign of A-B is the sum MSB corrected by overflow.
    assign resultNext = sltQ ? {{(WIDTH-1){1'b0}}, sumBit ^ ovfBit} : sumFull;

    always_comb begin
        stateD = stateQ;
        aSrD   = aSrQ;
        bSrD   = bSrQ;
        resSrD = resSrQ;
        carryD = carryQ;
        subD   = subQ;
        sltD   = sltQ;
        cntD   = cntQ;
        yD     = yQ;
        coutD  = coutQ;
        ovfD   = ovfQ;
        zeroD  = zeroQ;
        doneD  = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    aSrD   = a;
                    bSrD   = b;
                    resSrD = '0;
                    subD   = op[2];
                    sltD   = (op == 3'b111);
                    carryD = op[2];
                    cntD   = '0;
                    stateD = StRun;
                end
            end
            StRun: begin
                carryD = carryOut;
                resSrD = sumFull;
                aSrD   = aSrQ >> 1;
                bSrD   = bSrQ >> 1;
                cntD   = cntQ + CntW'(1);
                if (cntQ == LastCnt) begin
                    stateD = StIdle;
                    yD     = resultNext;
                    coutD  = carryOut;
                    ovfD   = ovfBit;
                    zeroD  = (resultNext == '0);
                    doneD  = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            aSrQ   <= '0;
            bSrQ   <= '0;
            resSrQ <= '0;
            carryQ <= 1'b0;
            subQ   <= 1'b0;
            sltQ   <= 1'b0;
            cntQ   <= '0;
            yQ     <= '0;
            coutQ  <= 1'b0;
            ovfQ   <= 1'b0;
            zeroQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            aSrQ   <= aSrD;
            bSrQ   <= bSrD;
            resSrQ <= resSrD;
            carryQ <= carryD;
            subQ   <= subD;
            sltQ   <= sltD;
            cntQ   <= cntD;
            yQ     <= yD;
            coutQ  <= coutD;
            ovfQ   <= ovfD;
            zeroQ  <= zeroD;
            doneQ  <= doneD;
        end
    end

    assign busy = (stateQ == StRun);
    assign done = doneQ;
    assign y    = yQ;
    assign cout = coutQ;
    assign ovf  = ovfQ;
    assign zero = zeroQ;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH = 8): directed vector table,
// randomized operations against an arithmetic reference model, and hand-written
// sequences for start-while-busy, back-to-back starts and reset during RUN.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk, rst_n, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] y;

    int nAssert = 0;
    int nFail   = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .y    (y),
        .cout (cout),
        .ovf  (ovf),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] y;
        logic         c;
        logic         v;
        logic         z;
    } vecT;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] mop,
                         output logic [W-1:0] my, output logic mc, output logic mv,
                         output logic mz);
        int sa, sb, sr, ua, ub, ur;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (mop[2]) begin
            ur = ua - ub;
            sr = sa - sb;
            mc = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            mc = (ur > 255);
        end
        mv = (sr > 127) || (sr < -128);
        my = W'(ur);
        if (mop == 3'b111) my = (sa < sb) ? W'(1) : W'(0);
        mz = (my == '0);
    endtask

    // Launch one operation and return the latency in cycles from the start edge
    // (0 if done never came). With b2b set the caller is already just after an
    // edge in the done cycle, so start is presented for the very next edge.
    task automatic doOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                        input bit holdStart, input bit b2b, output int lat);
        if (!b2b) @(negedge clk);
        a = ta;
        b = tb;
        op = top;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_start", busy, 1'b1);
        check("done_low_after_start", done, 1'b0);
        if (!holdStart) start = 1'b0;
        lat = 0;
        for (int k = 1; k <= W + 4; k++) begin
            if (holdStart) begin
                a = W'($urandom);
                b = W'($urandom);
                op = 3'($urandom);
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic checkResult(input string name, input logic [W-1:0] ey, input logic ec,
                               input logic ev, input logic ez);
        check({name, "_y"}, y, ey);
        check({name, "_cout"}, cout, ec);
        check({name, "_ovf"}, ovf, ev);
        check({name, "_zero"}, zero, ez);
        check({name, "_busy"}, busy, 1'b0);
    endtask

    vecT vecs[13];

    initial begin
        int lat;
        logic [W-1:0] ey, ra, rb;
        logic ec, ev, ez;
        logic [2:0] rop;
        bit sawDone;

        vecs[0]  = '{a: 8'h05, b: 8'h03, op: 3'b000, y: 8'h08, c: 0, v: 0, z: 0};
        vecs[1]  = '{a: 8'h05, b: 8'h05, op: 3'b100, y: 8'h00, c: 1, v: 0, z: 1};
        vecs[2]  = '{a: 8'h7F, b: 8'h01, op: 3'b000, y: 8'h80, c: 0, v: 1, z: 0};
        vecs[3]  = '{a: 8'h03, b: 8'h05, op: 3'b100, y: 8'hFE, c: 0, v: 0, z: 0};
        vecs[4]  = '{a: 8'h03, b: 8'h05, op: 3'b111, y: 8'h01, c: 0, v: 0, z: 0};
        vecs[5]  = '{a: 8'h80, b: 8'h01, op: 3'b111, y: 8'h01, c: 1, v: 1, z: 0};
        vecs[6]  = '{a: 8'hFF, b: 8'h01, op: 3'b000, y: 8'h00, c: 1, v: 0, z: 1};
        vecs[7]  = '{a: 8'h80, b: 8'h80, op: 3'b000, y: 8'h00, c: 1, v: 1, z: 1};
        vecs[8]  = '{a: 8'h10, b: 8'h20, op: 3'b011, y: 8'h30, c: 0, v: 0, z: 0};
        vecs[9]  = '{a: 8'h10, b: 8'h20, op: 3'b101, y: 8'hF0, c: 0, v: 0, z: 0};
        vecs[10] = '{a: 8'h00, b: 8'h00, op: 3'b100, y: 8'h00, c: 1, v: 0, z: 1};
        vecs[11] = '{a: 8'h05, b: 8'h03, op: 3'b111, y: 8'h00, c: 1, v: 0, z: 1};
        vecs[12] = '{a: 8'h7F, b: 8'h80, op: 3'b111, y: 8'h00, c: 0, v: 1, z: 1};

        rst_n = 1'b0;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_y", y, 8'h00);
        check("reset_flags", {cout, ovf, zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            doOp(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b0, lat);
            check($sformatf("vec%0d_latency", i), lat, W);
            checkResult($sformatf("vec%0d", i), vecs[i].y, vecs[i].c, vecs[i].v, vecs[i].z);
        end

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rop = 3'($urandom);
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rop, ey, ec, ev, ez);
            doOp(ra, rb, rop, 1'b0, 1'b0, lat);
            check($sformatf("rnd%0d_latency", i), lat, W);
            checkResult($sformatf("rnd%0d", i), ey, ec, ev, ez);
        end

        // Start held high through RUN while operands change: first capture wins
        doOp(8'h21, 8'h13, 3'b000, 1'b1, 1'b0, lat);
        check("hold_latency", lat, W);
        checkResult("hold", 8'h34, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start presented during the done cycle
        doOp(8'h40, 8'h41, 3'b100, 1'b0, 1'b0, lat);
        check("b2b_first_latency", lat, W);
        checkResult("b2b_first", 8'hFF, 1'b0, 1'b0, 1'b0);
        doOp(8'h40, 8'h41, 3'b111, 1'b0, 1'b1, lat);
        check("b2b_second_latency", lat, W);
        checkResult("b2b_second", 8'h01, 1'b0, 1'b0, 1'b0);

        // Reset during RUN: outputs clear immediately, no done afterwards
        doOp(8'h55, 8'h22, 3'b000, 1'b0, 1'b0, lat);
        checkResult("pre_reset", 8'h77, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hF0;
        b = 8'h0F;
        op = 3'b000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrun_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_y", y, 8'h00);
        check("abort_flags", {cout, ovf, zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        check("abort_no_done", sawDone, 1'b0);
        doOp(8'hF0, 8'h0F, 3'b000, 1'b0, 1'b0, lat);
        check("post_reset_latency", lat, W);
        checkResult("post_reset", 8'hFF, 1'b0, 1'b0, 1'b0);

        // done is a single-cycle pulse
        @(posedge clk);
        #1;
        check("done_pulse_width", done, 1'b0);
        check("y_holds", y, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial add/subtract unit for the ALU datapath, sitting directly downstream of the 2:1 operand mux. Each cycle it consumes one selected B bit, either `b` or `~b` chosen by `op[2]`, together with one A bit and a registered carry. It produces a `WIDTH`-bit result, flags and a one-cycle `done` pulse after `WIDTH` cycles. Start/done handshake; one operation in flight.

## Interface
- `WIDTH`, default 8: operand/result width, ≥2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: operation, captured with `start`.
  - `op[2]`=0: add.
  - `op[2]`=1: subtract (B inverted, carry-in 1).
  - `op`=3'b111: set-less-than (signed).
  - Other `op[1:0]` values: ignored.
- `a` in `WIDTH`: operand A, captured with `start`.
- `b` in `WIDTH`: operand B, captured with `start`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when results update.
- `y` out `WIDTH`: result; holds until the next completion.
- `cout` out 1: carry out of the MSB.
- `ovf` out 1: signed overflow.
- `zero` out 1: `y`==0.

## Operation
- States: IDLE, RUN.
- **IDLE**, on `start`=1:
  - Load shift registers `a_sr`←`a`, `b_sr`←`b`.
  - Latch `op`.
  - Set `carry`←`op[2]` and `cnt`←0.
  - Go to RUN.
- **RUN**, each cycle:
  - `bsel` = `op[2]` ? ~`b_sr[0]` : `b_sr[0]`.
  - `s` = `a_sr[0]` ^ `bsel` ^ `carry`.
  - `carry` ← majority(`a_sr[0]`, `bsel`, `carry`).
  - Shift `s` into the MSB of `res_sr` (LSB-first).
  - Shift `a_sr` and `b_sr` right; `cnt`++.
- Before the final bit (`cnt`==`WIDTH`-1), keep the carry entering the MSB as `cmsb`.
- On the final bit, go to IDLE and update the outputs:
  - `cout` = final carry.
  - `ovf` = `cmsb` ^ final carry.
  - `y` = sum, or for `op`=3'b111: {`WIDTH`-1 zeros, sum_msb ^ `ovf`}.
  - `zero` = (new `y`==0).
  - `done`=1.
- `start` while in RUN is ignored: no queuing, operands unchanged.
- `start` in the cycle `done` is high is accepted (back-to-back).
- Arithmetic is modulo 2^`WIDTH`. `cout` for subtract means no borrow (A ≥ B unsigned).

## Timing
- Reset (async assert): state IDLE; `busy`=0, `done`=0, `y`=0, `cout`=0, `ovf`=0, `zero`=0; internal registers cleared.
- Reset during RUN aborts the operation: no `done`, outputs go to reset values.
- Edge E0 samples `start`=1 → `busy`=1 from after E0.
- Edges E1..E`WIDTH` process bits 0..`WIDTH`-1.
- After E`WIDTH`:
  - `busy`=0, `done`=1, and `y`/flags valid.
  - Latency is `WIDTH` cycles from the start edge.
- `done` deasserts after E`WIDTH`+1. If `start` is high at E`WIDTH`+1, a new operation begins (`busy`=1) at that edge.
- Outputs change only at the completion edge or on reset. No combinational path from inputs to outputs.

## Test plan
- Reset, then `a`=0x05, `b`=0x03, `op`=000, `start` pulse → `done` exactly 8 cycles after the start edge, `y`=0x08, `cout`=0, `ovf`=0, `zero`=0.
- `a`=0x05, `b`=0x05, `op`=100 → `y`=0x00, `cout`=1, `zero`=1, `ovf`=0.
- `a`=0x7F, `b`=0x01, `op`=000 → `y`=0x80, `ovf`=1, `cout`=0.
- `a`=0x03, `b`=0x05, `op`=100 → `y`=0xFE, `cout`=0. Same operands with `op`=111 → `y`=0x01. With `a`=0x80, `b`=0x01, `op`=111 → `y`=0x01 (`ovf`=1 path).
- `start` held high through RUN with changing `a`/`b` → result reflects the first captured operands. Start asserted in the `done` cycle → second result follows 8 cycles later, no dead cycle.
- Assert `rst_n`=0 at cycle 4 of RUN → `busy`, `done`, `y` and flags all 0 immediately; no `done` pulse afterwards; next start completes normally.
